seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits; legal range 2..8.
REQ-002 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal minimum 2.
REQ-003 SHALL use one clock and a synchronous active-high reset: i_clk input, 1 bit, rising-edge clock.
REQ-004 SHALL have i_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have i_en  input  1  scan enable; low blanks the display.
REQ-006 SHALL have i_lzb  input  1  leading-zero blanking enable.
REQ-007 SHALL have i_valid  input  1  new display value offered.
REQ-008 SHALL have i_data  input  4*DIGITS  hex value; nibble k belongs to digit k, k=0 rightmost.
REQ-009 SHALL have o_ready  output  1  pending buffer free; transfer occurs when i_valid && o_ready at a rising edge.
REQ-010 SHALL have o_num  output  4  nibble of the current digit, fed to the 7-segment decoder.
REQ-011 SHALL have o_an  output  DIGITS  active-low digit select, at most one bit low.
REQ-012 SHALL have o_dig  output  $clog2(DIGITS)  current digit index.
REQ-013 SHALL have o_frame  output  1  one-cycle pulse after each scan wrap.

Function
REQ-014 SHALL hold two registers: pending (value plus full flag) and display; o_ready = !pending_full.
REQ-015 SHALL load i_data into pending and set full on an accepted transfer; i_data SHALL never write display directly.
REQ-016 SHALL have two states: IDLE (i_en=0) and SCAN (i_en=1); the state register follows i_en with one cycle of latency.
REQ-017 In IDLE: prescaler=0, index=0, o_an all ones; a full pending SHALL move to display on the next edge and clear full.
REQ-018 In SCAN: the prescaler SHALL count 0..DIV-1; tick = (prescaler==DIV-1), and the prescaler wraps to 0.
REQ-019 On tick: index SHALL advance by 1; at index DIGITS-1 it SHALL wrap to 0.
REQ-020 Frame boundary = tick with index DIGITS-1; on that edge a full pending SHALL move to display, full clears, and o_ready rises on the same edge.
REQ-021 On each frame-boundary edge o_frame SHALL be registered high for exactly one cycle.
REQ-022 A transfer accepted on a frame-boundary edge SHALL land in pending and reach display only at the following boundary (or in IDLE).
REQ-023 A transfer SHALL be impossible while pending is full; o_ready SHALL stay low until the pending value is consumed.
REQ-024 SCAN->IDLE mid-frame SHALL zero index and prescaler on the next edge; IDLE->SCAN SHALL start at index 0, prescaler 0.
REQ-025 o_num SHALL be combinational: display nibble[index]; o_dig = index.
REQ-026 o_an in SCAN SHALL drive bit[index] low and all other bits high; in IDLE, all bits high.
REQ-027 Blanking: h = index of the highest nonzero display nibble (0 if all zero); when i_lzb=1 and index>h, o_an SHALL be all ones; digit 0 SHALL never be blanked.
REQ-028 The prescaler width SHALL be $clog2(DIV), and no counter SHALL exceed its terminal value.

Reset
REQ-029 While i_rst=1 at an edge: state=IDLE, prescaler=0, index=0, display=0, pending=0, full=0, o_frame=0.
REQ-030 During and after reset until scan starts: o_ready=1, o_an all ones, o_num=0, o_dig=0.
REQ-031 Reset SHALL override all activity, including a simultaneous transfer or frame boundary; the offered data SHALL be dropped.

Verification (bench uses DIGITS=4, DIV=4)
REQ-032 Reset, i_en=1, then offer 0x1234: o_ready falls one cycle; o_an steps 1110,1101,1011,0111 every 4 cycles; o_num shows 4,3,2,1 after the first boundary.
REQ-033 Offer 0xABCD mid-frame: o_ready=0 until the boundary edge; the old digits finish the frame; the new frame shows D,C,B,A; o_frame pulses once.
REQ-034 Offer 0x5555 exactly on the boundary edge: the current frame shows the prior pending value; 0x5555 appears one frame later.
REQ-035 Display 0x0070 with i_lzb=1: digits 3 and 2 give o_an=1111, digits 1 and 0 are driven; with display 0x0000, only digit 0 is lit, showing 0.
REQ-036 Drop i_en at index 2: next edge o_an=1111, o_dig=0; a pending value loads in one cycle; re-raise i_en: scan restarts at digit 0 after a full DIV.
REQ-037 Assert i_rst mid-frame with i_valid high: next edge shows all outputs at reset values, display=0, o_ready=1.

Source files
------------

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with a one-deep pending buffer.
// Display updates only at frame boundaries or while idle.
module seg_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_lzb,
    input  logic                      i_valid,
    input  logic [4*DIGITS-1:0]       i_data,
    output logic                      o_ready,
    output logic [3:0]                o_num,
    output logic [DIGITS-1:0]         o_an,
    output logic [$clog2(DIGITS)-1:0] o_dig,
    output logic                      o_frame
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*DIGITS-1:0]     disp_q, disp_d;
    logic [4*DIGITS-1:0]     pend_q, pend_d;
    logic                    full_q, full_d;
    logic                    frame_q, frame_d;

    logic                    run;
    logic                    tick;
    logic                    bnd;
    logic                    load;
    logic                    accept;
    logic [DIGITS-1:0][3:0]  nib;
    logic [IW-1:0]           hi;
    logic                    blank;

    assign nib = disp_q;

    always_comb begin
        state_d = i_en ? SCAN : IDLE;
        pre_d   = '0;
        idx_d   = '0;
        disp_d  = disp_q;
        pend_d  = pend_q;
        full_d  = full_q;
        frame_d = 1'b0;
        run     = 1'b0;
        tick    = (pre_q == PRE_LAST);
        bnd     = 1'b0;
        load    = 1'b0;
        accept  = i_valid && !full_q;

        unique case (state_q)
            IDLE: begin
                load = 1'b1;
            end
            SCAN: begin
                // Dropping i_en zeroes the counters on the same edge
                run = i_en;
                if (run) begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    idx_d = idx_q;
                    if (tick) begin
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end
                    bnd  = tick && (idx_q == IDX_LAST);
                    load = bnd;
                end
            end
            default: ;
        endcase

        frame_d = bnd;
        if (load && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end
        if (accept) begin
            pend_d = i_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            full_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            frame_q <= frame_d;
        end
    end

    // Highest nonzero nibble; digit 0 is never above it
    always_comb begin
        hi = '0;
        for (int k = 1; k < DIGITS; k++) begin
            if (nib[k] != 4'd0) begin
                hi = IW'(k);
            end
        end
    end

    assign blank = i_lzb && (idx_q > hi);

    always_comb begin
        o_an = '1;
        if (state_q == SCAN && !blank) begin
            o_an[idx_q] = 1'b0;
        end
    end

    assign o_num   = nib[idx_q];
    assign o_dig   = idx_q;
    assign o_ready = !full_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized and directed bench for seg_scan against a
// frame-time reference model.
module tb_seg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        lzb;
    logic        valid;
    logic [15:0] data;
    logic        o_ready;
    logic [3:0]  o_num;
    logic [3:0]  o_an;
    logic [1:0]  o_dig;
    logic        o_frame;

    seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_lzb   (lzb),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (o_ready),
        .o_num   (o_num),
        .o_an    (o_an),
        .o_dig   (o_dig),
        .o_frame (o_frame)
    );

    always #5 clk = ~clk;

    // Model: scan time m_t counts cycles since scanning began
    bit          m_scan;
    int          m_t;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    bit          m_full;
    bit          m_frame;
    bit          m_acc;

    int checks = 0;
    int errors = 0;

    function automatic int exp_dig();
        return m_scan ? (m_t / DIV) % DIGITS : 0;
    endfunction

    function automatic int exp_num();
        return (int'(m_disp) >> (4 * exp_dig())) & 15;
    endfunction

    function automatic int exp_an();
        int d;
        int h;
        d = exp_dig();
        h = 0;
        for (int k = 0; k < DIGITS; k++)
            if (((int'(m_disp) >> (4 * k)) & 15) != 0) h = k;
        if (!m_scan) return 15;
        if (lzb && d > h) return 15;
        return (~(1 << d)) & 15;
    endfunction

    function automatic bit next_is_bnd();
        return m_scan && en && (m_t % FRAME == FRAME - 1);
    endfunction

    task automatic model_edge();
        bit bnd;
        bit old;
        m_acc = 1'b0;
        if (rst) begin
            m_scan  = 1'b0;
            m_t     = 0;
            m_pend  = '0;
            m_disp  = '0;
            m_full  = 1'b0;
            m_frame = 1'b0;
        end else begin
            bnd     = next_is_bnd();
            old     = m_full;
            m_frame = bnd;
            if ((!m_scan || bnd) && old) begin
                m_disp = m_pend;
                m_full = 1'b0;
            end
            if (valid && !old) begin
                m_pend = data;
                m_full = 1'b1;
                m_acc  = 1'b1;
            end
            m_t    = (m_scan && en) ? m_t + 1 : 0;
            m_scan = en;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ready", int'(o_ready), int'(!m_full));
        check("an",    int'(o_an),    exp_an());
        check("num",   int'(o_num),   exp_num());
        check("dig",   int'(o_dig),   exp_dig());
        check("frame", int'(o_frame), int'(m_frame));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [15:0] d);
        valid = 1'b1;
        data  = d;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_acc) break;
        end
        valid = 1'b0;
        check("offer_rdy", int'(o_ready), 0);
    endtask

    task automatic wait_dig(input int target);
        for (int i = 0; i < 64; i++) begin
            if (m_scan && exp_dig() == target) break;
            step();
        end
        check("wait_dig", int'(o_dig), target);
    endtask

    task automatic wait_bnd();
        for (int i = 0; i < 64; i++) begin
            if (next_is_bnd()) break;
            step();
        end
        check("wait_bnd", int'(o_dig), DIGITS - 1);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        lzb   = 1'b0;
        valid = 1'b0;
        data  = '0;
        steps(2);
        check("rst_an",    int'(o_an),    15);
        check("rst_ready", int'(o_ready), 1);
        check("rst_num",   int'(o_num),   0);
        rst = 1'b0;
        steps(2);

        // Scan start and first value
        en = 1'b1;
        offer(16'h1234);
        steps(2 * FRAME);

        // Mid-frame offer waits for the boundary
        wait_dig(1);
        offer(16'hABCD);
        steps(2 * FRAME + 3);

        // Offer landing exactly on the boundary edge
        wait_bnd();
        offer(16'h5555);
        steps(2 * FRAME);

        // Leading-zero blanking
        lzb = 1'b1;
        offer(16'h0070);
        steps(2 * FRAME);
        offer(16'h0000);
        steps(2 * FRAME);
        lzb = 1'b0;

        // Disable mid-frame with a pending value
        wait_dig(1);
        offer(16'h0F0F);
        wait_dig(2);
        en = 1'b0;
        step();
        check("idle_an",  int'(o_an),  15);
        check("idle_dig", int'(o_dig), 0);
        step();
        check("idle_num", int'(o_num), 15);
        steps(3);
        en = 1'b1;
        steps(2 * FRAME);

        // Reset during a transfer
        wait_dig(1);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 16'hFFFF;
        step();
        check("rr_ready", int'(o_ready), 1);
        check("rr_an",    int'(o_an),    15);
        check("rr_num",   int'(o_num),   0);
        check("rr_frame", int'(o_frame), 0);
        rst   = 1'b0;
        valid = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 19) != 0);
            lzb   = $urandom_range(0, 1) == 1;
            valid = $urandom_range(0, 3) == 0;
            data  = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
